// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back path.
package regfile_wb_arbiter_pkg;

    localparam int WB_XLEN  = 32;  // default data width
    localparam int WB_AW    = 5;   // default register address width
    localparam int NUM_REGS = 32;  // architectural register count
    localparam int ZERO_REG = 0;   // hard-wired zero register index

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant per cycle, search starts after the last winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N-1:0]         Req,
    input  logic                 En,
    output logic [N-1:0]         Gnt,
    output logic [$clog2(N)-1:0] Last
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] win_idx;
    logic          found;

    // Priority search from (last+1) mod N, wrapping; gated off when disabled.
    always_comb begin
        Gnt     = '0;
        found   = 1'b0;
        win_idx = last_q;
        for (int k = 1; k <= N; k++) begin
            if (!found && Req[(int'(last_q) + k) % N]) begin
                found                         = 1'b1;
                win_idx                       = IW'((int'(last_q) + k) % N);
                Gnt[(int'(last_q) + k) % N]   = 1'b1;
            end
        end
        if (!En) begin
            Gnt = '0;
        end
        last_d = (found && En) ? win_idx : last_q;
    end

    // Pointer resets to N-1 so requester 0 wins first.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

    assign Last = last_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port.
// Optional same-cycle read bypass enabled by defining WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = WB_XLEN,
    parameter int AW   = WB_AW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Hold,
    input  logic [NREQ-1:0]          Req_Valid,
    input  logic [NREQ*AW-1:0]       Req_DR,
    input  logic [NREQ*XLEN-1:0]     Req_Data,
    output logic [NREQ-1:0]          Req_Ready,
    output logic                     RegW,
    output logic [AW-1:0]            DR,
    output logic [XLEN-1:0]          Reg_In,
    output logic [$clog2(NREQ)-1:0]  Grant_Id
`ifdef WB_BYPASS_EN
    ,
    input  logic [AW-1:0]            SR1,
    input  logic [AW-1:0]            SR2,
    input  logic [XLEN-1:0]          ReadReg1,
    input  logic [XLEN-1:0]          ReadReg2,
    output logic [XLEN-1:0]          Fwd1,
    output logic [XLEN-1:0]          Fwd2
`endif
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   unused_arb_last;
    logic            any_gnt;
    logic [AW-1:0]   sel_dr;
    logic [XLEN-1:0] sel_data;
    logic [IW-1:0]   sel_id;

    logic            regw_q, regw_d;
    logic [AW-1:0]   dr_q, dr_d;
    logic [XLEN-1:0] reg_in_q, reg_in_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .CLK  (CLK),
        .RST  (RST),
        .Req  (Req_Valid),
        .En   (~Hold),
        .Gnt  (gnt),
        .Last (unused_arb_last)
    );

    assign Req_Ready = gnt;
    assign any_gnt   = |gnt;

    // Select payload of the one-hot granted requester.
    always_comb begin
        sel_dr   = '0;
        sel_data = '0;
        sel_id   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_dr   = Req_DR[i*AW +: AW];
                sel_data = Req_Data[i*XLEN +: XLEN];
                sel_id   = IW'(i);
            end
        end
    end

    // Next output-register state; writes to the zero register are consumed silently.
    always_comb begin
        regw_d     = any_gnt && (sel_dr != AW'(ZERO_REG));
        dr_d       = any_gnt ? sel_dr   : dr_q;
        reg_in_d   = any_gnt ? sel_data : reg_in_q;
        grant_id_d = any_gnt ? sel_id   : grant_id_q;
    end

    // Output register; async reset discards any in-flight write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            regw_q     <= 1'b0;
            dr_q       <= '0;
            reg_in_q   <= '0;
            grant_id_q <= '0;
        end else begin
            regw_q     <= regw_d;
            dr_q       <= dr_d;
            reg_in_q   <= reg_in_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign RegW     = regw_q;
    assign DR       = dr_q;
    assign Reg_In   = reg_in_q;
    assign Grant_Id = grant_id_q;

`ifdef WB_BYPASS_EN
    // Forward the write landing this cycle to same-cycle readers.
    always_comb begin
        Fwd1 = ReadReg1;
        Fwd2 = ReadReg2;
        if (regw_q && (dr_q == SR1) && (SR1 != AW'(ZERO_REG))) begin
            Fwd1 = reg_in_q;
        end
        if (regw_q && (dr_q == SR2) && (SR2 != AW'(ZERO_REG))) begin
            Fwd2 = reg_in_q;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (default build, NREQ=3).
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NV   = 16;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 Hold;
    logic [NREQ-1:0]      Req_Valid;
    logic [NREQ*AW-1:0]   Req_DR;
    logic [NREQ*XLEN-1:0] Req_Data;
    logic [NREQ-1:0]      Req_Ready;
    logic                 RegW;
    logic [AW-1:0]        DR;
    logic [XLEN-1:0]      Reg_In;
    logic [1:0]           Grant_Id;

    regfile_wb_arbiter #(
        .NREQ (NREQ),
        .XLEN (XLEN),
        .AW   (AW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Hold      (Hold),
        .Req_Valid (Req_Valid),
        .Req_DR    (Req_DR),
        .Req_Data  (Req_Data),
        .Req_Ready (Req_Ready),
        .RegW      (RegW),
        .DR        (DR),
        .Reg_In    (Reg_In),
        .Grant_Id  (Grant_Id)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                 hold;
        logic [NREQ-1:0]      valid;
        logic [NREQ*AW-1:0]   dr;
        logic [NREQ*XLEN-1:0] data;
        logic [NREQ-1:0]      exp_ready;
    } vec_t;

    typedef struct packed {
        logic        regw;
        logic [1:0]  id;
        logic [4:0]  dr;
        logic [31:0] data;
    } wr_t;

    vec_t tbl[NV];
    wr_t  sb_q[$];
    wr_t  held;
    wr_t  exp_w;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_v(input int v, input logic h, input logic [2:0] val, input logic [2:0] rdy);
        tbl[v].hold      = h;
        tbl[v].valid     = val;
        tbl[v].exp_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            tbl[v].dr[i*AW +: AW]       = 5'(((v * 3 + i) % 31) + 1);
            tbl[v].data[i*XLEN +: XLEN] = 32'hA000_0000 | 32'(v << 8) | 32'(i);
        end
    endtask

    initial begin
        // Expected ready hand-derived from round-robin order; pointer starts at 2.
        set_v(0,  1'b0, 3'b000, 3'b000);
        set_v(1,  1'b0, 3'b010, 3'b010);   // single write req1
        set_v(2,  1'b0, 3'b111, 3'b100);
        set_v(3,  1'b0, 3'b111, 3'b001);
        set_v(4,  1'b0, 3'b111, 3'b010);
        set_v(5,  1'b0, 3'b111, 3'b100);
        set_v(6,  1'b0, 3'b111, 3'b001);
        set_v(7,  1'b0, 3'b001, 3'b001);   // DR=0 write
        set_v(8,  1'b1, 3'b001, 3'b000);   // hold x4
        set_v(9,  1'b1, 3'b001, 3'b000);
        set_v(10, 1'b1, 3'b001, 3'b000);
        set_v(11, 1'b1, 3'b001, 3'b000);
        set_v(12, 1'b0, 3'b001, 3'b001);
        set_v(13, 1'b0, 3'b101, 3'b100);
        set_v(14, 1'b0, 3'b101, 3'b001);
        set_v(15, 1'b0, 3'b000, 3'b000);
        tbl[1].dr[1*AW +: AW]       = 5'd7;
        tbl[1].data[1*XLEN +: XLEN] = 32'hDEAD_BEEF;
        tbl[7].dr[0 +: AW]          = 5'd0;
        tbl[7].data[0 +: XLEN]      = 32'h55;

        RST = 1'b1; Hold = 1'b0; Req_Valid = '0; Req_DR = '0; Req_Data = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", 64'({RegW, Grant_Id, DR, Reg_In}), 64'(40'h0));
        check("reset_ready", 64'(Req_Ready), 64'(0));
        RST = 1'b0;

        held = '0;
        sb_q.push_back(held);
        for (int v = 0; v < NV; v++) begin
            @(posedge CLK);
            #1;
            exp_w = sb_q.pop_front();
            check($sformatf("out_v%0d", v), 64'({RegW, Grant_Id, DR, Reg_In}), 64'(exp_w));
            Hold      = tbl[v].hold;
            Req_Valid = tbl[v].valid;
            Req_DR    = tbl[v].dr;
            Req_Data  = tbl[v].data;
            #1;
            check($sformatf("ready_v%0d", v), 64'(Req_Ready), 64'(tbl[v].exp_ready));
            exp_w = held;
            exp_w.regw = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (tbl[v].exp_ready[i]) begin
                    exp_w.id   = 2'(i);
                    exp_w.dr   = tbl[v].dr[i*AW +: AW];
                    exp_w.data = tbl[v].data[i*XLEN +: XLEN];
                    exp_w.regw = (exp_w.dr != 5'd0);
                end
            end
            held = exp_w;
            sb_q.push_back(exp_w);
        end
        @(posedge CLK);
        #1;
        exp_w = sb_q.pop_front();
        check("out_final", 64'({RegW, Grant_Id, DR, Reg_In}), 64'(exp_w));

        // Mid-stream reset: in-flight write discarded immediately.
        Hold = 1'b0; Req_Valid = 3'b001; Req_DR = 15'd9; Req_Data = 96'h77;
        @(posedge CLK);
        #1;
        check("pre_rst_write", 64'({RegW, DR, Reg_In}), 64'({1'b1, 5'd9, 32'h77}));
        Req_Valid = '0;
        #2 RST = 1'b1;
        #1;
        check("rst_async", 64'({RegW, Grant_Id, DR, Reg_In}), 64'(40'h0));
        @(posedge CLK);
        #2 RST = 1'b0;

        // After release requester 0 wins over 2.
        @(posedge CLK);
        #1;
        Req_Valid = 3'b101;
        Req_DR    = {5'd4, 5'd0, 5'd3};
        Req_Data  = {32'h22, 32'h0, 32'h11};
        #1;
        check("post_rst_ready", 64'(Req_Ready), 64'(3'b001));
        @(posedge CLK);
        #1;
        check("post_rst_write", 64'({RegW, Grant_Id, DR, Reg_In}),
              64'({1'b1, 2'd0, 5'd3, 32'h11}));
        Req_Valid = 3'b100;
        #1;
        check("post_rst_next", 64'(Req_Ready), 64'(3'b100));
        @(posedge CLK);
        #1;
        check("post_rst_write2", 64'({RegW, Grant_Id, DR, Reg_In}),
              64'({1'b1, 2'd2, 5'd4, 32'h22}));
        Req_Valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
